// File: rtl/qam_mapper_axis.sv
// qam_mapper_axis
// Packs a byte-wide AXI-Stream payload into Gray-coded BPSK/QPSK/16-QAM/64-QAM
// I/Q symbols. Payload bits are consumed LSB first from a small bit buffer.
// The modulation order only changes at frame boundaries. A payload tlast
// flushes the buffer, zero-padding the final partial symbol.
module qam_mapper_axis #(
  parameter int DATA_W     = 8,
  parameter int MAX_ORDER  = 6,   // must be at least 6 so 64-QAM bits exist
  parameter int OUT_W      = 16,
  parameter int FRAME_SYMS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              m_in,
  input  logic [DATA_W-1:0]       s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic signed [OUT_W-1:0] m_axis_tdata_i,
  output logic signed [OUT_W-1:0] m_axis_tdata_q,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  localparam int BUF_W  = DATA_W + MAX_ORDER;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int CNT_W  = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;

  // Per-order amplitude scale so that every constellation has similar power.
  localparam int AMP_BPSK  = 16384;
  localparam int AMP_QPSK  = 11585;
  localparam int AMP_16QAM = 5181;
  localparam int AMP_64QAM = 2528;

  // Legal orders pass through, every other code falls back to QPSK.
  function automatic logic [2:0] decode_order(input logic [2:0] code);
    case (code)
      3'd1:    return 3'd1;
      3'd4:    return 3'd4;
      3'd6:    return 3'd6;
      default: return 3'd2;
    endcase
  endfunction

  // State
  logic [BUF_W-1:0]        bit_buf_reg;
  logic [FILL_W-1:0]       fill_reg;
  logic [2:0]              m_cur_reg;
  logic [CNT_W-1:0]        sym_cnt_reg;
  logic                    flush_reg;
  logic signed [OUT_W-1:0] data_i_reg;
  logic signed [OUT_W-1:0] data_q_reg;
  logic                    valid_reg;
  logic                    last_reg;

  // Datapath / control nets
  logic [BUF_W-1:0]        buf_left;
  logic [BUF_W-1:0]        beat_ext;
  logic [BUF_W-1:0]        bit_buf_next;
  logic [FILL_W-1:0]       order_fill;
  logic [FILL_W-1:0]       consumed;
  logic [FILL_W-1:0]       fill_left;
  logic [FILL_W-1:0]       fill_next;
  logic                    full_sym;
  logic                    out_free;
  logic                    load;
  logic                    accept;
  logic                    sym_last;
  logic                    drain;
  logic [MAX_ORDER-1:0]    sym_bits;
  logic [2:0]              gray_i;
  logic [2:0]              gray_q;
  logic [2:0]              idx_i;
  logic [2:0]              idx_q;
  logic signed [OUT_W-1:0] map_i;
  logic signed [OUT_W-1:0] map_q;
  int                      amp;
  int                      span;
  int                      lvl_i;
  int                      lvl_q;

  genvar gi;

  // A symbol is loaded when the output slot is free and either a whole
  // symbol is buffered or a flush needs the remaining partial symbol.
  assign order_fill = FILL_W'(m_cur_reg);
  assign full_sym   = fill_reg >= order_fill;
  assign out_free   = !valid_reg || m_axis_tready;
  assign load       = out_free && (full_sym || (flush_reg && fill_reg != '0));
  assign consumed   = load ? (full_sym ? order_fill : fill_reg) : '0;
  assign fill_left  = fill_reg - consumed;

  // Input acceptance ignores the output side so the buffer keeps filling
  // under backpressure until there is no room for another whole beat.
  assign s_axis_tready = !rst && !flush_reg && (fill_reg <= FILL_W'(BUF_W - DATA_W));
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Bits above fill are always zero, so shifting right discards the consumed
  // symbol and a partial flush symbol is zero-padded for free.
  assign buf_left     = bit_buf_reg >> consumed;
  assign beat_ext     = BUF_W'(s_axis_tdata);
  assign bit_buf_next = accept ? (buf_left | (beat_ext << fill_left)) : buf_left;
  assign fill_next    = accept ? (fill_left + FILL_W'(DATA_W)) : fill_left;

  // End of frame, or the load that empties the buffer during a flush.
  assign drain    = flush_reg && (fill_left == '0);
  assign sym_last = (sym_cnt_reg == CNT_W'(FRAME_SYMS - 1)) || drain;

  assign sym_bits = bit_buf_reg[MAX_ORDER-1:0];

  // Split the symbol into I (low half) and Q (high half) Gray codes,
  // zero-extended to three bits so one decoder serves every order.
  always_comb begin
    gray_i = '0;
    gray_q = '0;
    case (m_cur_reg)
      3'd4: begin
        gray_i = {1'b0, sym_bits[1:0]};
        gray_q = {1'b0, sym_bits[3:2]};
      end
      3'd6: begin
        gray_i = sym_bits[2:0];
        gray_q = sym_bits[5:3];
      end
      default: begin
        gray_i = {2'b00, sym_bits[0]};
        gray_q = {2'b00, sym_bits[1]};
      end
    endcase
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_gray
      assign idx_i[gi] = ^gray_i[2:gi];
      assign idx_q[gi] = ^gray_q[2:gi];
    end
  endgenerate

  // Map binary index to the symmetric PAM level 2*idx-(2^k-1) and scale.
  always_comb begin
    amp   = AMP_QPSK;
    span  = 1;
    lvl_i = 0;
    lvl_q = 0;
    map_i = '0;
    map_q = '0;
    case (m_cur_reg)
      3'd4: begin
        amp  = AMP_16QAM;
        span = 3;
      end
      3'd6: begin
        amp  = AMP_64QAM;
        span = 7;
      end
      default: ;
    endcase
    lvl_i = 2 * int'(idx_i) - span;
    lvl_q = 2 * int'(idx_q) - span;
    if (m_cur_reg == 3'd1) begin
      map_i = sym_bits[0] ? OUT_W'(AMP_BPSK) : OUT_W'(-AMP_BPSK);
      map_q = '0;
    end else begin
      map_i = OUT_W'(lvl_i * amp);
      map_q = OUT_W'(lvl_q * amp);
    end
  end

  // Bit buffer and fill count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_buf_reg <= '0;
      fill_reg    <= '0;
    end else begin
      bit_buf_reg <= bit_buf_next;
      fill_reg    <= fill_next;
    end
  end

  // Flush flag, frame counter and frame-boundary order latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_reg   <= 1'b0;
      sym_cnt_reg <= '0;
      m_cur_reg   <= 3'd2;
    end else begin
      if (accept && s_axis_tlast) begin
        flush_reg <= 1'b1;
      end else if (load && drain) begin
        flush_reg <= 1'b0;
      end
      if (load) begin
        sym_cnt_reg <= sym_last ? '0 : sym_cnt_reg + CNT_W'(1);
      end
      // The order may follow m_in while idle at a frame start, and is
      // re-sampled on the frame-ending load so a change made mid-frame
      // takes effect on the very next frame even in a continuous stream.
      if ((sym_cnt_reg == '0 && !load) || (load && sym_last)) begin
        m_cur_reg <= decode_order(m_in);
      end
    end
  end

  // Registered output slot: load a new symbol, or go idle once taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_i_reg <= '0;
      data_q_reg <= '0;
      valid_reg  <= 1'b0;
      last_reg   <= 1'b0;
    end else if (load) begin
      data_i_reg <= map_i;
      data_q_reg <= map_q;
      valid_reg  <= 1'b1;
      last_reg   <= sym_last;
    end else if (m_axis_tready) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end
  end

  assign m_axis_tdata_i = data_i_reg;
  assign m_axis_tdata_q = data_q_reg;
  assign m_axis_tvalid  = valid_reg;
  assign m_axis_tlast   = last_reg;

endmodule

// File: tb/tb_qam_mapper_axis.sv
// Testbench for qam_mapper_axis: directed constellation cases plus a random
// stream with random backpressure, checked against a bit-queue model.
module tb_qam_mapper_axis;

  localparam int FS = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [2:0]         m_in = 3'd2;
  logic [7:0]         s_tdata = 8'd0;
  logic               s_tvalid = 1'b0;
  logic               s_tlast = 1'b0;
  logic               s_tready;
  logic signed [15:0] m_i;
  logic signed [15:0] m_q;
  logic               m_tvalid;
  logic               m_tlast;
  logic               m_tready = 1'b0;

  qam_mapper_axis #(
    .DATA_W(8), .MAX_ORDER(6), .OUT_W(16), .FRAME_SYMS(FS)
  ) dut (
    .clk(clk), .rst(rst), .m_in(m_in),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata_i(m_i), .m_axis_tdata_q(m_q), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  bit mq[$];          // accepted payload bits not yet emitted, oldest first
  int flush_rem = 0;  // bits still to be flushed after a payload tlast
  int frame_cnt = 0;
  int frame_m   = 2;

  function automatic int decode_m(input int code);
    if (code == 1 || code == 4 || code == 6) return code;
    return 2;
  endfunction

  // Level for Gray code g on a 2^k-point axis: find idx whose Gray code is g.
  function automatic int gray_level(input int g, input int k);
    for (int idx = 0; idx < (1 << k); idx++)
      if ((idx ^ (idx >> 1)) == g) return 2 * idx - ((1 << k) - 1);
    return 0;
  endfunction

  function automatic int amp_of(input int m);
    if (m == 4) return 5181;
    if (m == 6) return 2528;
    return 11585;
  endfunction

  task automatic model_next(output int ei, output int eq, output int el, output bit ok);
    int nb;
    int k;
    int gi;
    int gq;
    bit drained;
    bit b[6];
    ok = 1'b1;
    drained = 1'b0;
    if (frame_cnt == 0) frame_m = decode_m(int'(m_in));
    if (flush_rem > 0) nb = (flush_rem < frame_m) ? flush_rem : frame_m;
    else if (mq.size() >= frame_m) nb = frame_m;
    else begin
      ok = 1'b0;
      nb = 0;
    end
    for (int j = 0; j < 6; j++) b[j] = 1'b0;
    for (int j = 0; j < nb; j++) b[j] = mq.pop_front();
    if (flush_rem > 0) begin
      flush_rem -= nb;
      drained = (flush_rem == 0);
    end
    el = (frame_cnt == FS - 1 || drained) ? 1 : 0;
    frame_cnt = (el != 0) ? 0 : frame_cnt + 1;
    if (frame_m == 1) begin
      ei = b[0] ? 16384 : -16384;
      eq = 0;
    end else begin
      k = frame_m / 2;
      gi = 0;
      gq = 0;
      for (int j = 0; j < k; j++) begin
        gi |= int'(b[j]) << j;
        gq |= int'(b[k + j]) << j;
      end
      ei = gray_level(gi, k) * amp_of(frame_m);
      eq = gray_level(gq, k) * amp_of(frame_m);
    end
  endtask

  // Monitor: sampled on the falling edge; handshakes seen here complete at
  // the following rising edge.
  initial begin
    bit hold_p;
    int hi;
    int hq;
    int hl;
    int ei;
    int eq;
    int el;
    bit ok;
    hold_p = 1'b0;
    hi = 0;
    hq = 0;
    hl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        flush_rem = 0;
        frame_cnt = 0;
        hold_p = 1'b0;
      end else begin
        if (hold_p) begin
          check_val("hold_valid", int'(m_tvalid), 1);
          check_val("hold_i", int'(m_i), hi);
          check_val("hold_q", int'(m_q), hq);
          check_val("hold_last", int'(m_tlast), hl);
        end
        hold_p = m_tvalid && !m_tready;
        hi = int'(m_i);
        hq = int'(m_q);
        hl = int'(m_tlast);
        if (m_tvalid && m_tready) begin
          $display("sym i=%0d q=%0d last=%0d", m_i, m_q, m_tlast);
          model_next(ei, eq, el, ok);
          check_val("sym_expected", int'(ok), 1);
          if (ok) begin
            check_val("sym_i", int'(m_i), ei);
            check_val("sym_q", int'(m_q), eq);
            check_val("sym_last", int'(m_tlast), el);
          end
        end
        if (s_tvalid && s_tready) begin
          for (int j = 0; j < 8; j++) mq.push_back(s_tdata[j]);
          if (s_tlast) flush_rem = mq.size();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) check_val("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((mq.size() != 0 || flush_rem != 0 || m_tvalid) && n < 600) begin
      n++;
      @(negedge clk);
    end
    check_val("drain_left", mq.size(), 0);
    check_val("drain_valid", int'(m_tvalid), 0);
    @(posedge clk);
    #1;
  endtask

  // First symbol of a lone beat: absent right after acceptance, present one
  // clock later with the given I/Q.
  task automatic check_first(input string tag, input int ei, input int eq);
    @(negedge clk);
    check_val({tag, "_early"}, int'(m_tvalid), 0);
    @(negedge clk);
    check_val({tag, "_valid"}, int'(m_tvalid), 1);
    check_val({tag, "_i"}, int'(m_i), ei);
    check_val({tag, "_q"}, int'(m_q), eq);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int total;
    int len;
    bit rand_on;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_sready", int'(s_tready), 0);
    check_val("rst_valid", int'(m_tvalid), 0);
    check_val("rst_i", int'(m_i), 0);
    check_val("rst_q", int'(m_q), 0);
    check_val("rst_last", int'(m_tlast), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_tready = 1'b1;
    idle(2);

    // QPSK 0xB4: 4th symbol ends both the frame and the flush
    send_beat(8'hB4, 1'b1);
    check_first("qpsk", -11585, -11585);
    wait_drain();

    // 16-QAM 0x1E
    m_in = 3'd4;
    idle(3);
    send_beat(8'h1E, 1'b1);
    check_first("qam16", 15543, 5181);
    wait_drain();

    // 64-QAM 0xFF with zero-padded tail
    m_in = 3'd6;
    idle(3);
    send_beat(8'hFF, 1'b1);
    check_first("qam64", 7584, 7584);
    wait_drain();
    @(negedge clk);
    check_val("flush_sready", int'(s_tready), 1);
    @(posedge clk);
    #1;

    // Order switch mid-frame takes effect on the next frame
    m_in = 3'd2;
    idle(3);
    send_beat(8'h5A, 1'b0);
    idle(2);
    m_in = 3'd4;
    send_beat(8'hC3, 1'b0);
    send_beat(8'h96, 1'b0);
    send_beat(8'h3C, 1'b1);
    wait_drain();

    // Backpressure for several clocks mid-stream
    m_in = 3'd2;
    idle(3);
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(8'($urandom), i == 7);
      end
      begin
        idle(3);
        m_tready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("bp_sready", int'(s_tready), 0);
        check_val("bp_valid", int'(m_tvalid), 1);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    wait_drain();

    // Random chunks with random order and random output backpressure
    total = 0;
    while (total < 1000) begin
      len = $urandom_range(1, 40);
      if (total + len > 1000) len = 1000 - total;
      m_in = 3'($urandom_range(0, 7));
      idle(3);
      rand_on = 1'b1;
      fork
        begin
          for (int i = 0; i < len; i++) begin
            send_beat(8'($urandom), i == len - 1);
            if ($urandom_range(0, 3) == 0) idle(1);
          end
          wait_drain();
          rand_on = 1'b0;
        end
        begin
          while (rand_on) begin
            @(posedge clk);
            #1;
            if (rand_on) m_tready = ($urandom_range(0, 3) != 0);
          end
        end
      join
      m_tready = 1'b1;
      total += len;
    end

    // Reset mid-frame with bits still buffered and a symbol held
    m_in = 3'd2;
    idle(3);
    m_tready = 1'b0;
    send_beat(8'hA5, 1'b0);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_sready", int'(s_tready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("mid_rst_valid", int'(m_tvalid), 0);
    check_val("mid_rst_i", int'(m_i), 0);
    check_val("mid_rst_q", int'(m_q), 0);
    check_val("mid_rst_last", int'(m_tlast), 0);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    idle(2);
    send_beat(8'h27, 1'b1);
    check_first("post_rst", 11585, 11585);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
